graphics_control: RTL and testbench

- FSM that sequences `graphics_datapath` to draw one 8x8 block per request.
- Optionally flashes the block white, holds it, then redraws it in its original colour.
- Sits between game logic (requester: go/flash_mode) and the datapath; drives the VGA adapter write enable (plot).
- Only one operation is in flight at a time; busy back-pressures the requester.

---
 rtl/graphics_control.sv | 171 +++++++++++++++++
 tb/tb_graphics_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/graphics_control.sv
// graphics_control: sequences graphics_datapath to draw one 8x8 block per
// request, optionally flashing it white, holding, then restoring the original
// colour.
//
// Ports:
//   clock        system clock
//   resetn       synchronous active-low reset
//   go           start request, sampled only in IDLE
//   flash_mode   sampled with go; 1 = draw/flash/hold/restore, 0 = draw only
//   load         datapath load (latch x/y/colour, clear pixel counter)
//   enable       datapath enable (advance pixel counter)
//   flash        datapath flash (colour <= white)
//   ld_previous  datapath restore of saved x/y/colour
//   plot         VGA write enable for the datapath's current pixel
//   busy         high in every state except IDLE
//   done         one-cycle pulse when an operation completes
module graphics_control #(
  parameter int unsigned PIXELS      = 64,
  parameter int unsigned HOLD_CYCLES = 12500000,
  parameter int unsigned HOLD_W      = 24
) (
  input  logic clock,
  input  logic resetn,
  input  logic go,
  input  logic flash_mode,
  output logic load,
  output logic enable,
  output logic flash,
  output logic ld_previous,
  output logic plot,
  output logic busy,
  output logic done
);

  localparam int unsigned PCNT_W = $clog2(PIXELS);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PIXELS - 1);
  localparam logic [HOLD_W-1:0] HCNT_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLASH_SET,
    S_FLASH_DRAW,
    S_HOLD,
    S_RESTORE_SET,
    S_RESTORE_DRAW,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
  logic                mode_q, mode_d;

  logic load_d, enable_d, flash_d, ld_previous_d, plot_d, busy_d, done_d;
  logic last_pixel;
  logic last_hold;

  assign last_pixel = (pcnt_q == PCNT_LAST);
  assign last_hold  = (hcnt_q == HCNT_LAST);

  // Next-state, counters, and Moore outputs decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    hcnt_d        = hcnt_q;
    mode_d        = mode_q;
    load_d        = 1'b0;
    enable_d      = 1'b0;
    flash_d       = 1'b0;
    ld_previous_d = 1'b0;
    plot_d        = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          mode_d  = flash_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pcnt_d  = '0;
        state_d = S_DRAW;
      end
      S_DRAW, S_FLASH_DRAW, S_RESTORE_DRAW: begin
        if (last_pixel) begin
          pcnt_d = '0;
          if (state_q == S_DRAW)            state_d = mode_q ? S_FLASH_SET : S_DONE;
          else if (state_q == S_FLASH_DRAW) state_d = S_HOLD;
          else                              state_d = S_DONE;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      S_FLASH_SET: state_d = S_FLASH_DRAW;
      S_HOLD: begin
        if (last_hold) begin
          hcnt_d  = '0;
          state_d = S_RESTORE_SET;
        end else begin
          hcnt_d = hcnt_q + HOLD_W'(1);
        end
      end
      S_RESTORE_SET: state_d = S_RESTORE_DRAW;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE: ;
      S_LOAD: begin
        load_d   = 1'b1;
        enable_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DRAW, S_FLASH_DRAW, S_RESTORE_DRAW: begin
        enable_d = 1'b1;
        plot_d   = 1'b1;
        busy_d   = 1'b1;
      end
      S_FLASH_SET: begin
        flash_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_HOLD: busy_d = 1'b1;
      S_RESTORE_SET: begin
        ld_previous_d = 1'b1;
        busy_d        = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, mode and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      mode_q      <= 1'b0;
      load        <= 1'b0;
      enable      <= 1'b0;
      flash       <= 1'b0;
      ld_previous <= 1'b0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      mode_q      <= mode_d;
      load        <= load_d;
      enable      <= enable_d;
      flash       <= flash_d;
      ld_previous <= ld_previous_d;
      plot        <= plot_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_graphics_control.sv
// tb_graphics_control: scoreboard bench for graphics_control. Accepted
// requests expand into the per-cycle output sequence the block should show;
// a monitor pops one entry per cycle and also tracks a minimal datapath
// (pixel counter and colour) to confirm plotted pixel index and colour.
module tb_graphics_control;

  localparam int unsigned PIXELS      = 64;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int unsigned HOLD_W      = 24;

  // Output vector order: {load, enable, flash, ld_previous, plot, busy, done}
  localparam logic [6:0] O_LOAD  = 7'b1000000;
  localparam logic [6:0] O_EN    = 7'b0100000;
  localparam logic [6:0] O_FLASH = 7'b0010000;
  localparam logic [6:0] O_LDP   = 7'b0001000;
  localparam logic [6:0] O_PLOT  = 7'b0000100;
  localparam logic [6:0] O_BUSY  = 7'b0000010;
  localparam logic [6:0] O_DONE  = 7'b0000001;

  typedef struct {
    logic [6:0] outs;
    bit         is_plot;
    int         pix;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic flash_mode = 1'b0;
  logic load, enable, flash, ld_previous, plot, busy, done;

  int checks = 0;
  int errors = 0;
  int busy_left = 0;
  bit mon_en = 1'b0;
  logic [2:0] next_colour = 3'b000;
  logic [2:0] cur_colour = 3'b000;

  graphics_control #(
    .PIXELS(PIXELS),
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W(HOLD_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .go(go),
    .flash_mode(flash_mode),
    .load(load),
    .enable(enable),
    .flash(flash),
    .ld_previous(ld_previous),
    .plot(plot),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  function automatic void push_one(logic [6:0] o, bit p, int pix, logic [2:0] c);
    exp_t e;
    e.outs = o;
    e.is_plot = p;
    e.pix = pix;
    e.col = c;
    exp_q.push_back(e);
  endfunction

  // Expected cycle-by-cycle behaviour of one operation, starting the cycle
  // after go is accepted.
  function automatic void push_op(bit fm, logic [2:0] col);
    push_one(O_LOAD | O_EN | O_BUSY, 1'b0, 0, 3'b000);
    for (int i = 0; i < int'(PIXELS); i++) push_one(O_EN | O_PLOT | O_BUSY, 1'b1, i, col);
    if (fm) begin
      push_one(O_FLASH | O_BUSY, 1'b0, 0, 3'b000);
      for (int i = 0; i < int'(PIXELS); i++) push_one(O_EN | O_PLOT | O_BUSY, 1'b1, i, 3'b111);
      for (int i = 0; i < int'(HOLD_CYCLES); i++) push_one(O_BUSY, 1'b0, 0, 3'b000);
      push_one(O_LDP | O_BUSY, 1'b0, 0, 3'b000);
      for (int i = 0; i < int'(PIXELS); i++) push_one(O_EN | O_PLOT | O_BUSY, 1'b1, i, col);
    end
    push_one(O_DONE | O_BUSY, 1'b0, 0, 3'b000);
  endfunction

  // One clock of stimulus; the request model decides acceptance itself.
  task automatic step(input logic g, input logic fm, input logic rn);
    go = g;
    flash_mode = fm;
    resetn = rn;
    @(posedge clock);
    if (!rn) begin
      exp_q.delete();
      busy_left = 0;
      mon_en = 1'b1;
    end else if (busy_left == 0 && g) begin
      int n0;
      n0 = exp_q.size();
      cur_colour = next_colour;
      push_op(fm, cur_colour);
      busy_left = exp_q.size() - n0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    #1;
  endtask

  task automatic drain();
    while (busy_left > 0) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor with a tiny datapath model (counter, colour, saved colour).
  logic [5:0] dp_cnt = 6'd0;
  logic [2:0] dp_col = 3'b000;
  logic [2:0] dp_saved = 3'b000;

  always @(negedge clock) begin
    if (mon_en) begin
      logic [6:0] act;
      exp_t e;
      act = {load, enable, flash, ld_previous, plot, busy, done};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.outs) begin
          errors++;
          $display("FAIL outputs t=%0t got=%b expected=%b", $time, act, e.outs);
        end
        if (e.is_plot) begin
          checks++;
          if (plot !== 1'b1 || dp_cnt !== 6'(e.pix) || dp_col !== e.col) begin
            errors++;
            $display("FAIL pixel t=%0t got plot=%b idx=%0d col=%b expected idx=%0d col=%b",
                     $time, plot, dp_cnt, dp_col, e.pix, e.col);
          end
        end
      end else begin
        checks++;
        if (act !== 7'b0) begin
          errors++;
          $display("FAIL idle t=%0t got=%b expected=0000000", $time, act);
        end
      end
      checks++;
      assert ($countones({load, flash, ld_previous}) <= 1 && (!plot || enable))
      else begin
        errors++;
        $display("FAIL exclusive t=%0t got load=%b flash=%b ldp=%b plot=%b enable=%b",
                 $time, load, flash, ld_previous, plot, enable);
      end
      if (load) begin
        dp_cnt = 6'd0;
        dp_col = cur_colour;
        dp_saved = cur_colour;
      end else begin
        if (enable) dp_cnt = dp_cnt + 6'd1;
        if (flash) dp_col = 3'b111;
        if (ld_previous) dp_col = dp_saved;
      end
    end
  end

  initial begin
    // Reset held two cycles with go high, then idle with go low.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // Draw-only.
    next_colour = 3'b010;
    step(1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);

    // Flash with colour 100.
    next_colour = 3'b100;
    step(1'b1, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);

    // go during a draw is ignored; go right after done is accepted.
    next_colour = 3'b011;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    drain();
    next_colour = 3'b110;
    step(1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);

    // Reset during HOLD aborts, then a plain draw behaves normally.
    next_colour = 3'b101;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 131; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    next_colour = 3'b001;
    step(1'b1, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);

    // Random requests, including go/flash_mode toggling while busy.
    for (int i = 0; i < 3000; i++) begin
      next_colour = 3'($urandom);
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d pending expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
